// File: rtl/pwm_decoder_pkg.sv
// Shared constants, state encoding and command payload for the PWM decoder.
package pwm_decoder_pkg;

  localparam int unsigned LEVEL_W        = 3;
  localparam int unsigned DATA_W         = 4;
  localparam int unsigned PERIOD_DEFAULT = 1000;

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  typedef struct packed {
    logic               dir;
    logic [LEVEL_W-1:0] level;
  } cmd_t;

  // Saturating increment of a duty level.
  function automatic logic [LEVEL_W-1:0] level_inc(input logic [LEVEL_W-1:0] lvl);
    return (lvl == LEVEL_MAX) ? lvl : lvl + LEVEL_W'(1);
  endfunction

endpackage

// File: rtl/pwm_decoder_if.sv
// Line-side inputs and decoded command outputs of the PWM decoder.
interface pwm_decoder_if;
  import pwm_decoder_pkg::*;

  logic              spd_in;
  logic              dir_in;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              stuck;

  modport master (output spd_in, output dir_in, input data_out, input valid, input stuck);
  modport slave  (input spd_in, input dir_in, output data_out, output valid, output stuck);

endinterface

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer with an extra stage for edge detection.
module pwm_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic       r_q1;
  logic       r_q2;
  logic       r_q3;
  logic [1:0] r_warm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q1   <= 1'b0;
      r_q2   <= 1'b0;
      r_q3   <= 1'b0;
      r_warm <= 2'd0;
    end else begin
      r_q1 <= i_async;
      r_q2 <= r_q1;
      r_q3 <= r_q2;
      if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
    end
  end

  // Edges are masked until all three stages hold real samples, so a line
  // already high at reset release is not mistaken for a rise.
  assign o_level  = r_q2;
  assign o_rise_c = (r_warm == 2'd3) &  r_q2 & ~r_q3;
  assign o_fall_c = (r_warm == 2'd3) & ~r_q2 &  r_q3;

endmodule

// File: rtl/pwm_decoder.sv
// Measures PWM high time on the speed line and rebuilds the {dir, level} command
// with a one-cycle valid strobe; idle or stuck lines are reported via timeouts.
module pwm_decoder
  import pwm_decoder_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES  = PERIOD_DEFAULT,
  parameter int unsigned STEP_CYCLES    = PERIOD_CYCLES / 8,
  parameter int unsigned TIMEOUT_CYCLES = 2 * PERIOD_CYCLES
) (
  input  logic         clk,
  input  logic         rst,
  pwm_decoder_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_FULL   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic w_spd_lvl;
  logic w_rise;
  logic w_fall;
  logic w_dir_lvl;
  logic w_dir_rise;
  logic w_dir_fall;
  logic w_unused;

  pwm_sync_edge u_spd_sync (
    .clk      (clk),
    .rst      (rst),
    .i_async  (bus.spd_in),
    .o_level  (w_spd_lvl),
    .o_rise_c (w_rise),
    .o_fall_c (w_fall)
  );

  pwm_sync_edge u_dir_sync (
    .clk      (clk),
    .rst      (rst),
    .i_async  (bus.dir_in),
    .o_level  (w_dir_lvl),
    .o_rise_c (w_dir_rise),
    .o_fall_c (w_dir_fall)
  );

  assign w_unused = w_dir_rise ^ w_dir_fall;

  state_e             r_state;
  logic [CNT_W-1:0]   r_pre;
  logic [LEVEL_W-1:0] r_lvl;
  logic [CNT_W-1:0]   r_time;
  logic               r_hi_to;
  cmd_t               r_cmd;
  logic               r_valid;
  logic               r_stuck;

  state_e             w_state_nx;
  logic [CNT_W-1:0]   w_pre_nx;
  logic [LEVEL_W-1:0] w_lvl_nx;
  logic [CNT_W-1:0]   w_time_nx;
  logic               w_hi_to_nx;
  cmd_t               w_cmd_nx;
  logic               w_valid_nx;
  logic               w_stuck_nx;
  logic               w_upd;
  logic [LEVEL_W-1:0] w_upd_lvl;
  logic               w_upd_to;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_pre   <= '0;
      r_lvl   <= '0;
      r_time  <= '0;
      r_hi_to <= 1'b0;
      r_cmd   <= '0;
      r_valid <= 1'b0;
      r_stuck <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pre   <= w_pre_nx;
      r_lvl   <= w_lvl_nx;
      r_time  <= w_time_nx;
      r_hi_to <= w_hi_to_nx;
      r_cmd   <= w_cmd_nx;
      r_valid <= w_valid_nx;
      r_stuck <= w_stuck_nx;
    end
  end

  // r_time counts the current run of the synchronized line (highs in HIGH,
  // lows otherwise); the sample that triggered the edge counts as the first.
  always_comb begin
    w_state_nx = r_state;
    w_pre_nx   = r_pre;
    w_lvl_nx   = r_lvl;
    w_time_nx  = r_time;
    w_hi_to_nx = r_hi_to;
    w_cmd_nx   = r_cmd;
    w_valid_nx = 1'b0;
    w_stuck_nx = r_stuck;
    w_upd      = 1'b0;
    w_upd_lvl  = '0;
    w_upd_to   = 1'b0;

    case (r_state)
      ST_IDLE, ST_LOW: begin
        if (w_rise) begin
          w_state_nx = ST_HIGH;
          w_pre_nx   = '0;
          w_lvl_nx   = '0;
          w_time_nx  = CNT_ONE;
          w_hi_to_nx = 1'b0;
        end else if ((r_state == ST_IDLE) && w_spd_lvl) begin
          w_time_nx = '0;
        end else if (r_time == TO_LAST) begin
          w_upd      = 1'b1;
          w_upd_lvl  = '0;
          w_upd_to   = 1'b1;
          w_time_nx  = TO_FULL;
          w_state_nx = ST_LOW;
        end else if (r_time != TO_FULL) begin
          w_time_nx = r_time + CNT_ONE;
        end
      end

      ST_HIGH: begin
        if (w_fall) begin
          w_state_nx = ST_LOW;
          w_time_nx  = CNT_ONE;
          w_hi_to_nx = 1'b0;
          if (!r_hi_to) begin
            w_upd     = 1'b1;
            w_upd_lvl = (r_pre == STEP_LAST) ? level_inc(r_lvl) : r_lvl;
          end
        end else if (!r_hi_to) begin
          if (r_pre == STEP_LAST) begin
            w_pre_nx = '0;
            w_lvl_nx = level_inc(r_lvl);
          end else begin
            w_pre_nx = r_pre + CNT_ONE;
          end
          if (r_time == TO_LAST) begin
            w_upd      = 1'b1;
            w_upd_lvl  = LEVEL_MAX;
            w_upd_to   = 1'b1;
            w_hi_to_nx = 1'b1;
            w_time_nx  = TO_FULL;
          end else begin
            w_time_nx = r_time + CNT_ONE;
          end
        end
      end

      default: w_state_nx = ST_IDLE;
    endcase

    if (w_upd) begin
      w_cmd_nx   = '{dir: w_dir_lvl, level: w_upd_lvl};
      w_valid_nx = 1'b1;
      w_stuck_nx = w_upd_to;
    end
  end

  assign bus.data_out = r_cmd;
  assign bus.valid    = r_valid;
  assign bus.stuck    = r_stuck;

endmodule

// File: tb/tb_pwm_decoder.sv
// Bench for pwm_decoder: run-length reference model checked every cycle,
// directed scenarios with literal expectations, then randomized pulse trains.
module tb_pwm_decoder;

  localparam int unsigned PERIOD = 1000;
  localparam int unsigned STEP   = PERIOD / 8;
  localparam int unsigned TMO    = 2 * PERIOD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_decoder_if u_if();

  pwm_decoder #(
    .PERIOD_CYCLES  (PERIOD),
    .STEP_CYCLES    (STEP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  // Reference model: line samples through two stages, run lengths of the sampled line.
  logic       m_s1, m_s2, m_lprev, m_d1, m_d2;
  int         m_ec, m_run;
  logic       m_run_val, m_track, m_hto;
  logic [3:0] exp_data;
  logic       exp_valid, exp_stuck;

  logic [4:0] log_q[$];

  task automatic m_update(input int lvl, input logic st, input logic d);
    exp_data  = {d, 3'(lvl)};
    exp_valid = 1'b1;
    exp_stuck = st;
  endtask

  initial begin
    logic l_now, l_prev, d_now;
    int   held;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_s1 = 0; m_s2 = 0; m_lprev = 0; m_d1 = 0; m_d2 = 0;
        m_ec = 0; m_run = 0; m_run_val = 0; m_track = 0; m_hto = 0;
        exp_data = 4'h0; exp_valid = 0; exp_stuck = 0;
      end else begin
        l_now  = m_s2;
        l_prev = m_lprev;
        d_now  = m_d2;
        m_lprev = l_now;
        m_s2 = m_s1; m_s1 = u_if.spd_in;
        m_d2 = m_d1; m_d1 = u_if.dir_in;
        if (m_ec < 10) m_ec++;
        held = m_run;
        if (l_now == m_run_val) begin
          if (m_run < int'(TMO) + 1) m_run++;
        end else begin
          m_run_val = l_now;
          m_run     = 1;
        end
        exp_valid = 1'b0;
        if (m_track) begin
          if (!l_now && l_prev) begin
            if (!m_hto) m_update((held / int'(STEP) > 7) ? 7 : held / int'(STEP), 1'b0, d_now);
            m_track = 0;
          end else if (l_now && m_run == int'(TMO) && !m_hto) begin
            m_update(7, 1'b1, d_now);
            m_hto = 1;
          end
        end else begin
          if (l_now && !l_prev && m_ec >= 4) begin
            m_track = 1;
            m_hto   = 0;
          end else if (!l_now && m_run == int'(TMO)) begin
            m_update(0, 1'b1, d_now);
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus a log of every DUT update.
  initial begin
    logic [5:0] got, exp;
    forever begin
      @(negedge clk);
      #1;
      if (cmp_en) begin
        got = {u_if.data_out, u_if.valid, u_if.stuck};
        exp = {exp_data, exp_valid, exp_stuck};
        n_checks++;
        if (got !== exp) begin
          n_errors++;
          $display("FAIL cycle_cmp t=%0t got{data,valid,stuck}=%b required=%b", $time, got, exp);
        end
        if (u_if.valid === 1'b1) log_q.push_back({u_if.stuck, u_if.data_out});
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    u_if.spd_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_log(input string name, input int idx, input logic [4:0] exp);
    if (idx < log_q.size()) chk(name, 32'(log_q[idx]), 32'(exp));
    else chk(name, 32'hdead, 32'(exp));
  endtask

  initial begin
    int lat;
    u_if.spd_in = 1'b0;
    u_if.dir_in = 1'b1;
    #2 rst = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_data", 32'(u_if.data_out), 32'h0);
    chk("reset_valid", 32'(u_if.valid), 32'h0);
    chk("reset_stuck", 32'(u_if.stuck), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 5);

    // 40 % duty, dir=1
    log_q.delete();
    repeat (4) begin drive(1'b1, 400); drive(1'b0, 600); end
    chk("duty_count", 32'(log_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk_log("duty_word", i, 5'b0_1011);

    // Saturation with short low gaps, dir=0
    log_q.delete();
    u_if.dir_in = 1'b0;
    repeat (3) begin drive(1'b1, 998); drive(1'b0, 2); end
    drive(1'b0, 10);
    chk("sat_count", 32'(log_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) chk_log("sat_word", i, 5'b0_0111);

    // Low-line timeout after a 250-cycle pulse
    log_q.delete();
    u_if.dir_in = 1'b1;
    drive(1'b1, 250);
    drive(1'b0, 2500);
    chk("lowto_count", 32'(log_q.size()), 32'd2);
    chk_log("lowto_pulse", 0, 5'b0_1010);
    chk_log("lowto_timeout", 1, 5'b1_1000);

    // High-line timeout, ignored fall, then a clean 125-cycle pulse
    log_q.delete();
    u_if.dir_in = 1'b0;
    drive(1'b1, 3000);
    drive(1'b0, 200);
    chk("hito_count_after_fall", 32'(log_q.size()), 32'd1);
    drive(1'b1, 125);
    drive(1'b0, 200);
    chk("hito_count", 32'(log_q.size()), 32'd2);
    chk_log("hito_timeout", 0, 5'b1_0111);
    chk_log("hito_recover", 1, 5'b0_0001);

    // Reset in the middle of a high pulse
    log_q.delete();
    u_if.dir_in = 1'b1;
    drive(1'b1, 200);
    rst = 1'b0;
    #1;
    chk("rstmid_data", 32'(u_if.data_out), 32'h0);
    chk("rstmid_valid", 32'(u_if.valid), 32'h0);
    chk("rstmid_stuck", 32'(u_if.stuck), 32'h0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 295);
    drive(1'b0, 300);
    chk("rstmid_no_partial", 32'(log_q.size()), 32'd0);
    drive(1'b1, 750);
    drive(1'b0, 100);
    chk("rstmid_count", 32'(log_q.size()), 32'd1);
    chk_log("rstmid_word", 0, 5'b0_1110);

    // Fall-to-valid latency
    drive(1'b1, 300);
    u_if.spd_in = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (lat == 0 && u_if.valid === 1'b1) begin
        lat = k;
        chk("latency_word", 32'(u_if.data_out), 32'hA);
      end
    end
    chk("latency_edges", 32'(lat), 32'd3);
    @(negedge clk);
    drive(1'b0, 50);

    // Randomized pulse trains, occasionally long enough to time out
    for (int i = 0; i < 24; i++) begin
      int hl, ll;
      hl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1900, 2300)) : int'($urandom_range(2, 1100));
      ll = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1900, 2300)) : int'($urandom_range(2, 1100));
      if ($urandom_range(0, 1) == 1) u_if.dir_in = 1'($urandom_range(0, 1));
      drive(1'b1, hl);
      if ($urandom_range(0, 3) == 0) u_if.dir_in = 1'($urandom_range(0, 1));
      drive(1'b0, ll);
    end
    drive(1'b0, 50);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
